// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer/control unit for the 32-bit RISC datapath: decodes the
// opcode into the packed control vector and steps FETCH/DECODE/EXEC/MEM/WB.
module cpu_seq_ctrl #(
  parameter bit         MULTI_CYCLE_MDU = 1'b1,
  parameter int         CNT_W           = 32,
  parameter logic [4:0] OPCODE_HLT      = 5'd31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_req,
  input  logic [4:0]       opcode,
  input  logic             imm,
  input  logic             alu_done,
  output logic [21:0]      cu_ctrl,
  output logic             ir_en,
  output logic             pc_en,
  output logic             regwr_en,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             alu_start,
  output logic             sram_sel,
  output logic             busy,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int B_ST = 0,  B_LD = 1,  B_BEQ = 2,  B_BGT = 3,  B_RET = 4,  B_IMM = 5;
  localparam int B_WB = 6,  B_UBR = 7, B_CALL = 8, B_ADD = 9,  B_SUB = 10, B_CMP = 11;
  localparam int B_MUL = 12, B_DIV = 13, B_MOD = 14, B_LSL = 15, B_LSR = 16, B_ASR = 17;
  localparam int B_OR = 18, B_AND = 19, B_NOT = 20, B_MOV = 21;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  // Bit 22 of the result flags a decodable opcode; bits 21:0 are the control vector.
  function automatic logic [22:0] decode_op(input logic [4:0] op, input logic imm_bit);
    logic [21:0] c;
    logic        legal;
    c     = 22'd0;
    legal = 1'b1;
    case (op)
      5'd0:  begin c[B_ADD] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd1:  begin c[B_SUB] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd2:  begin c[B_MUL] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd3:  begin c[B_DIV] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd4:  begin c[B_MOD] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd5:  begin c[B_CMP] = 1'b1; c[B_IMM] = imm_bit; end
      5'd6:  begin c[B_AND] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd7:  begin c[B_OR]  = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd8:  begin c[B_NOT] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd9:  begin c[B_MOV] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd10: begin c[B_LSL] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd11: begin c[B_LSR] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd12: begin c[B_ASR] = 1'b1; c[B_WB] = 1'b1; c[B_IMM] = imm_bit; end
      5'd13: c = 22'd0;
      5'd14: begin c[B_LD] = 1'b1; c[B_ADD] = 1'b1; c[B_IMM] = 1'b1; c[B_WB] = 1'b1; end
      5'd15: begin c[B_ST] = 1'b1; c[B_ADD] = 1'b1; c[B_IMM] = 1'b1; end
      5'd16: c[B_BEQ] = 1'b1;
      5'd17: c[B_BGT] = 1'b1;
      5'd18: c[B_UBR] = 1'b1;
      5'd19: begin c[B_CALL] = 1'b1; c[B_UBR] = 1'b1; c[B_WB] = 1'b1; end
      5'd20: begin c[B_RET] = 1'b1; c[B_UBR] = 1'b1; end
      5'd31: c = 22'd0;
      default: legal = 1'b0;
    endcase
    return {legal, c};
  endfunction

  state_t             state_q, state_d;
  logic [21:0]        cu_ctrl_q, cu_ctrl_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  logic               ir_en_q, pc_en_q, regwr_en_q, dmem_rd_q, dmem_wr_q, alu_start_q;
  logic               alu_start_d;
  logic               sram_sel_q, busy_q, halted_q;
  logic [22:0]        dec_s;
  logic               mdu_wait_s;

  assign dec_s      = decode_op(opcode, imm);
  assign mdu_wait_s = MULTI_CYCLE_MDU && (cu_ctrl_q[B_MUL] || cu_ctrl_q[B_DIV] || cu_ctrl_q[B_MOD]);

  // Next-state, control-vector latch, sticky illegal flag and retire counter.
  always_comb begin
    state_d     = state_q;
    cu_ctrl_d   = cu_ctrl_q;
    illegal_d   = illegal_q;
    instr_cnt_d = instr_cnt_q;
    alu_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_req)   state_d = S_LOAD;
        else if (start) state_d = S_FETCH;
        else            state_d = S_IDLE;
      end
      S_LOAD: begin
        if (load_req) state_d = S_LOAD;
        else          state_d = S_IDLE;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OPCODE_HLT) begin
          state_d = S_HALT;
        end else if (!dec_s[22]) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d     = S_EXEC;
          cu_ctrl_d   = dec_s[21:0];
          alu_start_d = MULTI_CYCLE_MDU && (dec_s[B_MUL] || dec_s[B_DIV] || dec_s[B_MOD]);
        end
      end
      S_EXEC: begin
        // alu_done in the same cycle as alu_start already ends the wait.
        if (mdu_wait_s && !alu_done)              state_d = S_EXEC;
        else if (cu_ctrl_q[B_LD] || cu_ctrl_q[B_ST]) state_d = S_MEM;
        else                                      state_d = S_WB;
      end
      S_MEM: state_d = S_WB;
      S_WB: begin
        instr_cnt_d = instr_cnt_q + CNT_W'(1);
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State, control vector and outputs; strobes are registered from the next state
  // so each one is high exactly while the sequencer sits in its owning state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cu_ctrl_q   <= 22'd0;
      illegal_q   <= 1'b0;
      instr_cnt_q <= '0;
      ir_en_q     <= 1'b0;
      pc_en_q     <= 1'b0;
      regwr_en_q  <= 1'b0;
      dmem_rd_q   <= 1'b0;
      dmem_wr_q   <= 1'b0;
      alu_start_q <= 1'b0;
      sram_sel_q  <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cu_ctrl_q   <= cu_ctrl_d;
      illegal_q   <= illegal_d;
      instr_cnt_q <= instr_cnt_d;
      ir_en_q     <= (state_d == S_FETCH);
      pc_en_q     <= (state_d == S_WB);
      regwr_en_q  <= (state_d == S_WB) && cu_ctrl_d[B_WB];
      dmem_rd_q   <= (state_d == S_MEM) && cu_ctrl_d[B_LD];
      dmem_wr_q   <= (state_d == S_MEM) && cu_ctrl_d[B_ST];
      alu_start_q <= alu_start_d;
      sram_sel_q  <= (state_d == S_LOAD);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q    <= (state_d == S_HALT);
    end
  end

  assign cu_ctrl    = cu_ctrl_q;
  assign ir_en      = ir_en_q;
  assign pc_en      = pc_en_q;
  assign regwr_en   = regwr_en_q;
  assign dmem_rd    = dmem_rd_q;
  assign dmem_wr    = dmem_wr_q;
  assign alu_start  = alu_start_q;
  assign sram_sel   = sram_sel_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign illegal_op = illegal_q;
  assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: per-instruction expectations are queued at
// fetch and compared by a negedge monitor when the WB pc_en strobe appears.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst2 = 1'b1;
  logic        start = 1'b0, start2 = 1'b0, load_req = 1'b0;
  logic [4:0]  opcode = 5'd13;
  logic        imm = 1'b0, alu_done = 1'b0;
  logic [21:0] cu_ctrl, d2_cu_ctrl;
  logic        ir_en, pc_en, regwr_en, dmem_rd, dmem_wr, alu_start, sram_sel, busy, halted, illegal_op;
  logic        d2_ir_en, d2_pc_en, d2_regwr_en, d2_dmem_rd, d2_dmem_wr, d2_alu_start;
  logic        d2_sram_sel, d2_busy, d2_halted, d2_illegal_op;
  logic [31:0] instr_cnt, d2_instr_cnt;

  cpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .load_req(load_req), .opcode(opcode), .imm(imm),
    .alu_done(alu_done), .cu_ctrl(cu_ctrl), .ir_en(ir_en), .pc_en(pc_en), .regwr_en(regwr_en),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .alu_start(alu_start), .sram_sel(sram_sel),
    .busy(busy), .halted(halted), .illegal_op(illegal_op), .instr_cnt(instr_cnt));

  cpu_seq_ctrl #(.MULTI_CYCLE_MDU(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .load_req(load_req), .opcode(opcode), .imm(imm),
    .alu_done(alu_done), .cu_ctrl(d2_cu_ctrl), .ir_en(d2_ir_en), .pc_en(d2_pc_en),
    .regwr_en(d2_regwr_en), .dmem_rd(d2_dmem_rd), .dmem_wr(d2_dmem_wr), .alu_start(d2_alu_start),
    .sram_sel(d2_sram_sel), .busy(d2_busy), .halted(d2_halted), .illegal_op(d2_illegal_op),
    .instr_cnt(d2_instr_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] ctrl;
    int          lat;
    bit          wb, rd, wr;
    int          as_n;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   idx = 0, rw_idx = -1, rd_idx = -1, wr_idx = -1, as_n = 0, sel_cnt = 0, d2_as_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: tracks strobe positions relative to ir_en, checks at pc_en.
  always @(negedge clk) begin
    exp_t e;
    if (sram_sel) sel_cnt++;
    if (d2_alu_start) d2_as_cnt++;
    chk("strobe_excl", 64'(int'(ir_en) + int'(dmem_rd) + int'(dmem_wr) + int'(alu_start)
                          + int'(pc_en | regwr_en) > 1), 64'd0);
    if (ir_en) begin
      idx = 0; rw_idx = -1; rd_idx = -1; wr_idx = -1; as_n = 0;
    end else begin
      idx++;
    end
    if (regwr_en)  rw_idx = idx;
    if (dmem_rd)   rd_idx = idx;
    if (dmem_wr)   wr_idx = idx;
    if (alu_start) as_n++;
    if (regwr_en && !pc_en) chk("regwr_without_pc_en", 64'd1, 64'd0);
    if (pc_en) begin
      if (sb.size() == 0) begin
        chk("pc_en_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_cycle",  64'(idx), 64'(e.lat - 1));
        chk("cu_ctrl",   64'(cu_ctrl), 64'(e.ctrl));
        chk("regwr_idx", 64'(rw_idx), 64'(e.wb ? idx : -1));
        chk("dmem_rd",   64'(rd_idx), 64'(e.rd ? 3 : -1));
        chk("dmem_wr",   64'(wr_idx), 64'(e.wr ? 3 : -1));
        chk("alu_start", 64'(as_n), 64'(e.as_n));
        chk("instr_cnt", 64'(instr_cnt), 64'(e.cnt));
      end
    end
  end

  task automatic wait_sig(input string tag, input int which);
    int n = 0;
    while (!((which == 0) ? ir_en : (which == 1) ? pc_en : (which == 2) ? alu_start : dmem_wr)
           && n < 60) begin
      @(negedge clk); n++;
    end
    if (n >= 60) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_instr(input logic [4:0] i_op, input logic i_imm, input logic [21:0] i_ctrl,
                           input int i_lat, input bit i_wb, input bit i_rd, input bit i_wr,
                           input int i_as, input logic [31:0] i_cnt, input int i_dly);
    exp_t e;
    wait_sig("fetch", 0);
    opcode = i_op; imm = i_imm;
    e.ctrl = i_ctrl; e.lat = i_lat; e.wb = i_wb; e.rd = i_rd; e.wr = i_wr;
    e.as_n = i_as; e.cnt = i_cnt;
    sb.push_back(e);
    if (i_as > 0) begin
      @(negedge clk);
      wait_sig("alu_start", 2);
      repeat (i_dly) @(negedge clk);
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
    end
    wait_sig("pc_en", 1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_cu_ctrl", 64'(cu_ctrl), 64'd0);
    chk("rst_strobes", 64'({ir_en, pc_en, regwr_en, dmem_rd, dmem_wr, alu_start}), 64'd0);
    chk("rst_status", 64'({sram_sel, busy, halted, illegal_op}), 64'd0);
    chk("rst_instr_cnt", 64'(instr_cnt), 64'd0);

    rst = 1'b0;
    @(negedge clk);
    load_req = 1'b1;
    repeat (8) @(negedge clk);
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("sram_sel_cycles", 64'(sel_cnt), 64'd8);
    chk("idle_after_load", 64'({sram_sel, busy}), 64'd0);

    opcode = 5'd0; imm = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("fetch_after_start", 64'({ir_en, busy}), 64'b11);
    run_instr(5'd0,  1'b1, 22'h000260, 4,  1, 0, 0, 0, 32'd0, 0);   // add imm
    start = 1'b0;
    run_instr(5'd14, 1'b0, 22'h000262, 5,  1, 1, 0, 0, 32'd1, 0);   // ld
    run_instr(5'd15, 1'b0, 22'h000221, 5,  0, 0, 1, 0, 32'd2, 0);   // st
    run_instr(5'd2,  1'b0, 22'h001040, 10, 1, 0, 0, 1, 32'd3, 6);   // mul, done +6
    run_instr(5'd16, 1'b1, 22'h000004, 4,  0, 0, 0, 0, 32'd4, 0);   // beq
    run_instr(5'd19, 1'b0, 22'h0001C0, 4,  1, 0, 0, 0, 32'd5, 0);   // call
    run_instr(5'd1,  1'b0, 22'h000440, 4,  1, 0, 0, 0, 32'd6, 0);   // sub reg
    run_instr(5'd5,  1'b1, 22'h000820, 4,  0, 0, 0, 0, 32'd7, 0);   // cmp imm
    run_instr(5'd3,  1'b1, 22'h002060, 4,  1, 0, 0, 1, 32'd8, 0);   // div, done with start
    chk("instr_cnt_9", 64'(instr_cnt), 64'd9);

    wait_sig("fetch", 0);
    opcode = 5'd25;
    repeat (3) @(negedge clk);
    chk("illegal_halt", 64'({halted, illegal_op, busy}), 64'b110);
    start = 1'b1;
    repeat (10) @(negedge clk);
    chk("illegal_stays", 64'({halted, illegal_op, ir_en}), 64'b110);

    rst = 1'b1;
    @(negedge clk);
    chk("rst_clears_illegal", 64'({halted, illegal_op}), 64'd0);
    opcode = 5'd31;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("hlt_halts", 64'({halted, illegal_op, busy}), 64'b100);
    repeat (5) @(negedge clk);
    chk("hlt_stays", 64'({halted, ir_en, instr_cnt}), {31'd0, 1'b1, 1'b0, 32'd0});

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    opcode = 5'd0; imm = 1'b1;
    @(negedge clk);
    run_instr(5'd0, 1'b1, 22'h000260, 4, 1, 0, 0, 0, 32'd0, 0);
    wait_sig("fetch", 0);
    opcode = 5'd15;
    wait_sig("dmem_wr", 3);
    chk("pre_rst_cnt", 64'({dmem_wr, instr_cnt}), {31'd0, 1'b1, 32'd1});
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", 64'({cu_ctrl, dmem_wr, pc_en, regwr_en, busy, sram_sel}), 64'd0);
    chk("mid_rst_cnt", 64'(instr_cnt), 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 64'({busy, ir_en, halted}), 64'd0);

    opcode = 5'd2; imm = 1'b1; start2 = 1'b1; rst2 = 1'b0;
    n = 0;
    while (!d2_ir_en && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!d2_ir_en && n < 30);
    chk("mdu0_period", 64'(n), 64'd4);
    chk("mdu0_cu_ctrl", 64'(d2_cu_ctrl), 64'h1060);
    chk("mdu0_cnt", 64'(d2_instr_cnt), 64'd1);
    chk("mdu0_no_alu_start", 64'(d2_as_cnt), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
